sargantana_flush_ctrl: RTL and testbench

//  Initiator side of the icache invalidation sweep. Accepts flush requests
//  (fence.i / sfence) from the core and waits for any in-flight refill to

---
 rtl/sargantana_flush_ctrl.sv | 113 +++++++++++
 tb/tb_sargantana_flush_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sargantana_flush_ctrl.sv
// Icache flush initiator: drains in-flight refills, drives a full valid-bit
// sweep through the external index generator, then acknowledges the core.
module sargantana_flush_ctrl #(
    parameter int unsigned ICACHE_DEPTH = 64,
    parameter int unsigned ICACHE_WAYS  = 4,
    localparam int unsigned ADDR_WIDTH  = $clog2(ICACHE_DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_req_i,
    input  logic                   refill_busy_i,
    input  logic [ADDR_WIDTH-1:0]  sweep_addr_i,
    input  logic                   sweep_done_i,
    output logic                   sweep_en_o,
    output logic                   valid_clr_o,
    output logic [ADDR_WIDTH-1:0]  valid_clr_addr_o,
    output logic [ICACHE_WAYS-1:0] valid_clr_way_o,
    output logic                   fetch_stall_o,
    output logic                   flush_ack_o,
    output logic                   flush_err_o
);

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(ICACHE_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  pend;
    logic                  pend_next;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_next;
    logic                  err;
    logic                  err_set;

    // State, pending-request, watchdog counter and sticky error registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            pend  <= 1'b0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            pend  <= pend_next;
            cnt   <= cnt_next;
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // Next-state logic; a request landing in DONE re-arms directly so it is never lost
    always_comb begin
        state_next = state;
        pend_next  = pend;
        cnt_next   = cnt;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (flush_req_i) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!refill_busy_i) begin
                    state_next = SWEEP;
                end
            end
            SWEEP: begin
                cnt_next  = cnt + ADDR_WIDTH'(1);
                pend_next = pend | flush_req_i;
                if (sweep_done_i) begin
                    state_next = DONE;
                end else if (cnt == CNT_LAST) begin
                    err_set    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                cnt_next   = '0;
                pend_next  = 1'b0;
                state_next = (pend || flush_req_i) ? DRAIN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state only
    always_comb begin
        sweep_en_o       = 1'b0;
        valid_clr_o      = 1'b0;
        valid_clr_addr_o = '0;
        valid_clr_way_o  = '0;
        fetch_stall_o    = (state != IDLE);
        flush_ack_o      = (state == DONE);
        flush_err_o      = err;
        if (state == SWEEP) begin
            sweep_en_o       = 1'b1;
            valid_clr_o      = 1'b1;
            valid_clr_addr_o = sweep_addr_i;
            valid_clr_way_o  = '1;
        end
    end

endmodule

// File: tb/tb_sargantana_flush_ctrl.sv
// Scoreboard bench for sargantana_flush_ctrl with a behavioural sweep generator.
module tb_sargantana_flush_ctrl;

    localparam int DEPTH = 64;
    localparam int WAYS  = 4;
    localparam int AW    = 6;

    typedef struct {
        bit is_ack;
        int addr;
        int cyc;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush_req = 1'b0;
    logic          refill_busy = 1'b0;
    logic [AW-1:0] gen_addr;
    logic          sweep_done;
    logic          force_no_done = 1'b0;
    logic          sweep_en;
    logic          valid_clr;
    logic [AW-1:0] valid_clr_addr;
    logic [WAYS-1:0] valid_clr_way;
    logic          fetch_stall;
    logic          flush_ack;
    logic          flush_err;

    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;
    ev_t exp_q[$];

    sargantana_flush_ctrl #(.ICACHE_DEPTH(DEPTH), .ICACHE_WAYS(WAYS)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_req_i      (flush_req),
        .refill_busy_i    (refill_busy),
        .sweep_addr_i     (gen_addr),
        .sweep_done_i     (sweep_done),
        .sweep_en_o       (sweep_en),
        .valid_clr_o      (valid_clr),
        .valid_clr_addr_o (valid_clr_addr),
        .valid_clr_way_o  (valid_clr_way),
        .fetch_stall_o    (fetch_stall),
        .flush_ack_o      (flush_ack),
        .flush_err_o      (flush_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sweep index generator sharing the reset; done can be suppressed to trip the watchdog
    always @(posedge clk) begin
        if (rst) gen_addr <= '0;
        else if (sweep_en) gen_addr <= gen_addr + 6'd1;
    end
    assign sweep_done = (gen_addr == 6'(DEPTH - 1)) && !force_no_done;

    function automatic void chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endfunction

    // Monitor: every clear or ack the DUT presents is matched against the queue head
    always @(negedge clk) begin
        if (mon_en && (valid_clr || flush_ack)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", int'({valid_clr, flush_ack}), 0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("stall_active", int'(fetch_stall), 1);
                if (e.is_ack) begin
                    chk("ack", int'(flush_ack), 1);
                    chk("clr_during_ack", int'(valid_clr), 0);
                end else begin
                    chk("clr", int'(valid_clr), 1);
                    chk("clr_addr", int'(valid_clr_addr), e.addr);
                    chk("clr_way", int'(valid_clr_way), 15);
                    chk("sweep_en", int'(sweep_en), 1);
                    chk("ack_during_clr", int'(flush_ack), 0);
                end
            end
        end
    end

    task automatic push_sweep(input int start);
        ev_t e;
        for (int i = 0; i < DEPTH; i++) begin
            e.is_ack = 1'b0; e.addr = i; e.cyc = start + i;
            exp_q.push_back(e);
        end
        e.is_ack = 1'b1; e.addr = 0; e.cyc = start + DEPTH;
        exp_q.push_back(e);
    endtask

    // Request visible during cycle k (sampled at the end of it); returns in cycle k+1
    task automatic pulse_req(output int k);
        @(posedge clk); #1;
        flush_req = 1'b1;
        k = cyc;
        @(posedge clk); #1;
        flush_req = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_q(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic chk_quiet(string tag);
        chk({tag, "_stall"}, int'(fetch_stall), 0);
        chk({tag, "_clr"}, int'(valid_clr), 0);
        chk({tag, "_en"}, int'(sweep_en), 0);
        chk({tag, "_ack"}, int'(flush_ack), 0);
    endtask

    initial begin
        int k;
        int s;

        // Reset state
        step(3);
        chk_quiet("reset");
        chk("reset_err", int'(flush_err), 0);
        rst = 1'b0;
        mon_en = 1'b1;
        step(2);

        // 1: idle refill, full sweep 0..63 on k+2..k+65, ack at k+66
        pulse_req(k);
        push_sweep(k + 2);
        chk("t1_stall_drain", int'(fetch_stall), 1);
        chk("t1_no_clr_drain", int'(valid_clr), 0);
        wait_q(300);
        chk_quiet("t1_idle");

        // 2: refill busy for 5 cycles delays the sweep by 4
        step(2);
        @(posedge clk); #1;
        flush_req = 1'b1;
        refill_busy = 1'b1;
        k = cyc;
        push_sweep(k + 6);
        step(1);
        flush_req = 1'b0;
        step(3);
        chk("t2_stall_busy", int'(fetch_stall), 1);
        chk("t2_no_clr_busy", int'(valid_clr), 0);
        step(1);
        refill_busy = 1'b0;
        wait_q(300);
        chk_quiet("t2_idle");

        // 3: request at sweep addr 20 -> second full sweep after first ack
        step(2);
        pulse_req(k);
        s = k + 2;
        push_sweep(s);
        push_sweep(s + 66);
        step(20);
        pulse_req(k);
        wait_q(400);
        chk_quiet("t3_idle");

        // 4: three requests (two in SWEEP, one in DONE) coalesce into one extra sweep
        step(2);
        pulse_req(k);
        s = k + 2;
        push_sweep(s);
        push_sweep(s + 66);
        step(10);
        pulse_req(k);
        step(28);
        pulse_req(k);
        step(22);
        pulse_req(k);
        chk("t4_req_in_done", k, s + 64);
        wait_q(400);
        chk_quiet("t4_idle");

        // 5: generator never reports done -> watchdog error after 64 sweep cycles
        step(2);
        chk("t5_err_before", int'(flush_err), 0);
        force_no_done = 1'b1;
        pulse_req(k);
        push_sweep(k + 2);
        wait_q(300);
        chk("t5_err_set", int'(flush_err), 1);
        step(5);
        chk("t5_err_sticky", int'(flush_err), 1);
        chk_quiet("t5_idle");
        force_no_done = 1'b0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t5_err_cleared", int'(flush_err), 0);

        // 6: reset at sweep addr 30 -> no ack, next sweep restarts at 0
        step(2);
        pulse_req(k);
        s = k + 2;
        for (int i = 0; i <= 30; i++) begin
            ev_t e;
            e.is_ack = 1'b0; e.addr = i; e.cyc = s + i;
            exp_q.push_back(e);
        end
        step(31);
        chk("t6_pre_rst_addr", int'(valid_clr_addr), 30);
        rst = 1'b1;
        step(1);
        chk_quiet("t6_after_rst");
        rst = 1'b0;
        chk("t6_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        step(3);
        chk_quiet("t6_no_ack");
        pulse_req(k);
        push_sweep(k + 2);
        wait_q(300);
        chk_quiet("t6_idle");
        chk("t6_err", int'(flush_err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
